// File: rtl/pulse_rate_controller.sv
// pulse_rate_controller: encoder/button front end and burst FSM that gates an LFSR pulse generator.
// Optional feature macro PULSE_RATE_AUTO_REPEAT_EN: bursts repeat after cooldown until the next press.
module pulse_rate_controller #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned COOLDOWN  = 1024,
  parameter int unsigned DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn,
  input  logic       pulse_in,
  output logic [1:0] frequency,
  output logic       pulse_out,
  output logic       burst_active,
  output logic [7:0] pulse_count
);

  localparam logic [7:0]  BURST_LEN_C = 8'(BURST_LEN);
  localparam logic [15:0] COOLDOWN_C  = 16'(COOLDOWN);
  localparam logic [7:0]  DEB_LAST_C  = 8'(DEBOUNCE - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_COOL  = 2'b10
  } state_t;

  logic [1:0]  enc_meta_r;
  logic [1:0]  enc_sync_r;
  logic [1:0]  enc_prev_r;
  logic        btn_meta_r;
  logic        btn_sync_r;
  logic        deb_level_r;
  logic        deb_level_d_r;
  logic [7:0]  deb_cnt_r;
  logic        req_r;
  logic        pin_s1_r;
  logic        pin_s2_r;
  logic [1:0]  pending_r;
  logic [1:0]  freq_r;
  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [15:0] timer_r;
  logic        pulse_out_r;
  logic        burst_active_r;

  logic        deb_level_s;
  logic [7:0]  deb_cnt_s;
  logic [1:0]  pending_s;
  logic        pin_edge_s;
  logic        freq_load_s;
  state_t      state_s;
  logic [7:0]  cnt_s;
  logic [15:0] timer_s;
  logic        strobe_s;

  // Position of a code along the forward gray sequence 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] code);
    case (code)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // Modulo-4 movement between two encoder codes: 1 forward, 3 backward, 0/2 no step.
  function automatic logic [1:0] enc_dir(input logic [1:0] prev, input logic [1:0] cur);
    enc_dir = gray_pos(cur) - gray_pos(prev);
  endfunction

  assign pin_edge_s = pin_s1_r & ~pin_s2_r;

  // Two-flop synchronisers, previous encoder pair and generator pulse history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_meta_r <= 2'b00;
      enc_sync_r <= 2'b00;
      enc_prev_r <= 2'b00;
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      pin_s1_r   <= 1'b0;
      pin_s2_r   <= 1'b0;
    end else begin
      enc_meta_r <= {enc_a, enc_b};
      enc_sync_r <= enc_meta_r;
      enc_prev_r <= enc_sync_r;
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
      pin_s1_r   <= pulse_in;
      pin_s2_r   <= pin_s1_r;
    end
  end

  // Debounce: the level flips only after DEBOUNCE consecutive disagreeing cycles.
  always_comb begin
    deb_level_s = deb_level_r;
    deb_cnt_s   = 8'd0;
    if (btn_sync_r != deb_level_r) begin
      if (deb_cnt_r == DEB_LAST_C) begin
        deb_level_s = btn_sync_r;
        deb_cnt_s   = 8'd0;
      end else begin
        deb_cnt_s = deb_cnt_r + 8'd1;
      end
    end else begin
      deb_cnt_s = 8'd0;
    end
  end

  // Debounced level, its delayed copy and the registered rising-edge request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level_r   <= 1'b0;
      deb_level_d_r <= 1'b0;
      deb_cnt_r     <= 8'd0;
      req_r         <= 1'b0;
    end else begin
      deb_level_r   <= deb_level_s;
      deb_level_d_r <= deb_level_r;
      deb_cnt_r     <= deb_cnt_s;
      req_r         <= deb_level_r & ~deb_level_d_r;
    end
  end

  // Saturating pending rate from the quadrature step.
  always_comb begin
    pending_s = pending_r;
    case (enc_dir(enc_prev_r, enc_sync_r))
      2'd1:    pending_s = (pending_r == 2'd3) ? 2'd3 : pending_r + 2'd1;
      2'd3:    pending_s = (pending_r == 2'd0) ? 2'd0 : pending_r - 2'd1;
      default: pending_s = pending_r;
    endcase
  end

  // Burst FSM next state, forwarded-pulse count, cooldown timer and strobe.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    timer_s  = timer_r;
    strobe_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_r) begin
          state_s = ST_BURST;
          cnt_s   = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (req_r) begin
`ifdef PULSE_RATE_AUTO_REPEAT_EN
          state_s = ST_IDLE;
`else
          state_s = ST_COOL;
          timer_s = COOLDOWN_C;
`endif
        end else if (pin_edge_s) begin
          strobe_s = 1'b1;
          cnt_s    = cnt_r + 8'd1;
          if ((cnt_r + 8'd1) == BURST_LEN_C) begin
            state_s = ST_COOL;
            timer_s = COOLDOWN_C;
          end else begin
            state_s = ST_BURST;
          end
        end else begin
          state_s = ST_BURST;
        end
      end
      ST_COOL: begin
`ifdef PULSE_RATE_AUTO_REPEAT_EN
        if (req_r) begin
          state_s = ST_IDLE;
        end else if (timer_r == 16'd1) begin
          state_s = ST_BURST;
          cnt_s   = 8'd0;
        end else begin
          timer_s = timer_r - 16'd1;
        end
`else
        if (timer_r == 16'd1) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r - 16'd1;
        end
`endif
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
        timer_s = 16'd0;
      end
    endcase
  end

`ifdef PULSE_RATE_AUTO_REPEAT_EN
  assign freq_load_s = (state_r == ST_IDLE) || (state_r == ST_COOL) || (state_s == ST_IDLE);
`else
  assign freq_load_s = (state_r == ST_IDLE) || (state_s == ST_IDLE);
`endif

  // Rate select, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r      <= 2'b00;
      freq_r         <= 2'b00;
      state_r        <= ST_IDLE;
      cnt_r          <= 8'd0;
      timer_r        <= 16'd0;
      pulse_out_r    <= 1'b0;
      burst_active_r <= 1'b0;
    end else begin
      pending_r      <= pending_s;
      freq_r         <= freq_load_s ? pending_r : freq_r;
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      timer_r        <= timer_s;
      pulse_out_r    <= strobe_s;
      burst_active_r <= (state_s == ST_BURST);
    end
  end

  assign frequency    = freq_r;
  assign pulse_out    = pulse_out_r;
  assign burst_active = burst_active_r;
  assign pulse_count  = cnt_r;

endmodule

// File: tb/tb_pulse_rate_controller.sv
// Self-checking bench for pulse_rate_controller: timeline model of the controller plus directed scenarios
// and a randomized phase; honours PULSE_RATE_AUTO_REPEAT_EN when defined.
module tb_pulse_rate_controller;

  localparam int BL = 4;
  localparam int CD = 10;
  localparam int DB = 4;
`ifdef PULSE_RATE_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       btn = 1'b0;
  logic       pulse_in = 1'b0;
  logic [1:0] frequency;
  logic       pulse_out;
  logic       burst_active;
  logic [7:0] pulse_count;

  int checks = 0;
  int errors = 0;

  pulse_rate_controller #(.BURST_LEN(BL), .COOLDOWN(CD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .btn(btn), .pulse_in(pulse_in),
    .frequency(frequency), .pulse_out(pulse_out), .burst_active(burst_active), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int gray_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_code(input int pos);
    case (pos % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int enc_step(input logic [1:0] from, input logic [1:0] to);
    int d;
    d = (gray_pos(to) - gray_pos(from) + 4) % 4;
    if (d == 1) return 1;
    if (d == 3) return -1;
    return 0;
  endfunction

  // Reference timeline: samples taken at each edge, phases, and cooldown deadline as a cycle number.
  typedef enum int {M_IDLE, M_BURST, M_COOL} mphase_t;
  logic [1:0] m_enc [3];
  logic       m_btn [2];
  logic       m_pin [2];
  int         m_pending, m_freq, m_run, m_cnt, m_cool_end;
  logic       m_level, m_level_d, m_req, m_pout;
  mphase_t    m_ph;
  int         cyc_n = 0;

  always @(posedge clk) begin : model_step
    int      np;
    logic    nlevel;
    mphase_t nph;
    int      ncnt;
    logic    strobe;
    logic    pedge;
    cyc_n++;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_enc[i] = 2'b00;
      for (int i = 0; i < 2; i++) begin m_btn[i] = 1'b0; m_pin[i] = 1'b0; end
      m_pending = 0; m_freq = 0; m_run = 0; m_cnt = 0; m_cool_end = 0;
      m_level = 1'b0; m_level_d = 1'b0; m_req = 1'b0; m_pout = 1'b0; m_ph = M_IDLE;
    end else begin
      nph = m_ph; ncnt = m_cnt; strobe = 1'b0;
      pedge = m_pin[0] && !m_pin[1];
      case (m_ph)
        M_IDLE: if (m_req) begin nph = M_BURST; ncnt = 0; end
        M_BURST: begin
          if (m_req) begin
            if (AUTO) nph = M_IDLE;
            else begin nph = M_COOL; m_cool_end = cyc_n + CD; end
          end else if (pedge) begin
            strobe = 1'b1;
            ncnt = m_cnt + 1;
            if (ncnt == BL) begin nph = M_COOL; m_cool_end = cyc_n + CD; end
          end
        end
        default: begin
          if (AUTO && m_req) nph = M_IDLE;
          else if (cyc_n == m_cool_end) begin
            if (AUTO) begin nph = M_BURST; ncnt = 0; end
            else nph = M_IDLE;
          end
        end
      endcase
      if (m_ph == M_IDLE || nph == M_IDLE || (AUTO && m_ph == M_COOL)) m_freq = m_pending;
      np = m_pending + enc_step(m_enc[2], m_enc[1]);
      m_pending = (np > 3) ? 3 : ((np < 0) ? 0 : np);
      nlevel = m_level;
      if (m_btn[1] != m_level) begin
        m_run++;
        if (m_run == DB) begin nlevel = m_btn[1]; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_req = m_level && !m_level_d;
      m_level_d = m_level;
      m_level = nlevel;
      m_ph = nph; m_cnt = ncnt; m_pout = strobe;
      m_enc[2] = m_enc[1]; m_enc[1] = m_enc[0]; m_enc[0] = {enc_a, enc_b};
      m_btn[1] = m_btn[0]; m_btn[0] = btn;
      m_pin[1] = m_pin[0]; m_pin[0] = pulse_in;
    end
  end

  int         strobes = 0;
  int         rises = 0;
  int         fall_cyc = 0;
  int         fchg_cyc = 0;
  logic       ba_q = 1'b0;
  logic [1:0] f_q = 2'b00;

  // Per-cycle comparison against the model, plus event bookkeeping for directed checks.
  always @(posedge clk) begin
    #2;
    check("frequency", int'(frequency), m_freq);
    check("pulse_out", int'(pulse_out), int'(m_pout));
    check("burst_active", int'(burst_active), (m_ph == M_BURST) ? 1 : 0);
    check("pulse_count", int'(pulse_count), m_cnt);
    if (pulse_out) strobes++;
    if (burst_active && !ba_q) rises++;
    if (!burst_active && ba_q) fall_cyc = cyc_n;
    if (frequency != f_q) fchg_cyc = cyc_n;
    ba_q = burst_active;
    f_q = frequency;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    btn = 1'b1;
    cyc(hold);
    btn = 1'b0;
  endtask

  task automatic pulse_once();
    pulse_in = 1'b1;
    cyc(1);
    pulse_in = 1'b0;
    cyc(1);
  endtask

  int pos = 0;
  int exp_up [5] = '{1, 2, 3, 3, 3};
  int exp_dn [5] = '{2, 1, 0, 0, 0};
  int base_s;
  int base_r;
  int hold;
  int rst_at;
  int r;

  initial begin
    // Reset held with random inputs.
    rst_n = 1'b0;
    repeat (6) begin
      enc_a = 1'($urandom); enc_b = 1'($urandom); btn = 1'($urandom); pulse_in = 1'($urandom);
      @(negedge clk);
    end
    check("rst_frequency", int'(frequency), 0);
    check("rst_pulse_out", int'(pulse_out), 0);
    check("rst_burst_active", int'(burst_active), 0);
    check("rst_pulse_count", int'(pulse_count), 0);
    enc_a = 1'b0; enc_b = 1'b0; btn = 1'b0; pulse_in = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(100);
    check("idle_frequency", int'(frequency), 0);
    check("idle_burst_active", int'(burst_active), 0);
    check("idle_pulse_count", int'(pulse_count), 0);

    // Encoder saturation up, down, and a double-bit jump.
    for (int i = 0; i < 5; i++) begin
      pos = (pos + 1) % 4; {enc_a, enc_b} = gray_code(pos);
      cyc(5);
      check("enc_cw", int'(frequency), exp_up[i]);
    end
    for (int i = 0; i < 5; i++) begin
      pos = (pos + 3) % 4; {enc_a, enc_b} = gray_code(pos);
      cyc(5);
      check("enc_ccw", int'(frequency), exp_dn[i]);
    end
    pos = (pos + 2) % 4; {enc_a, enc_b} = gray_code(pos);
    cyc(5);
    check("enc_jump", int'(frequency), 0);
    pos = (pos + 2) % 4; {enc_a, enc_b} = gray_code(pos);
    cyc(5);

    // Burst of BL pulses with frozen frequency, then cooldown.
    press(8);
    check("burst_start", int'(burst_active), 1);
    check("burst_count0", int'(pulse_count), 0);
    for (int i = 0; i < 2; i++) begin
      pos = (pos + 1) % 4; {enc_a, enc_b} = gray_code(pos);
      cyc(2);
    end
    cyc(4);
    check("freq_frozen", int'(frequency), 0);
    base_s = strobes;
    for (int i = 0; i < 6; i++) pulse_once();
    check("burst_strobes", strobes - base_s, BL);
    check("burst_count", int'(pulse_count), BL);
    check("burst_ended", int'(burst_active), 0);
`ifndef PULSE_RATE_AUTO_REPEAT_EN
    check("freq_cool_frozen", int'(frequency), 0);
`endif
    cyc(8);
    check("freq_applied", int'(frequency), 2);
`ifdef PULSE_RATE_AUTO_REPEAT_EN
    check("cool_freq_delay", fchg_cyc - fall_cyc, 1);
    check("auto_repeat", int'(burst_active), 1);
    check("auto_repeat_count", int'(pulse_count), 0);
    press(8);
    check("auto_stop", int'(burst_active), 0);
    cyc(10);
`else
    check("cool_length", fchg_cyc - fall_cyc, CD);
    check("idle_after_cool", int'(burst_active), 0);
`endif

    // Abort after two pulses; the simultaneous pulse edge is dropped.
    press(8);
    check("abort_start", int'(burst_active), 1);
    cyc(8);
    base_s = strobes;
    pulse_once();
    pulse_once();
    cyc(2);
    check("abort_pre_count", int'(pulse_count), 2);
    btn = 1'b1;
    cyc(6);
    pulse_in = 1'b1;
    cyc(1);
    pulse_in = 1'b0;
    cyc(3);
    btn = 1'b0;
    cyc(8);
    check("abort_no_strobe", strobes - base_s, 2);
    check("abort_count_hold", int'(pulse_count), 2);
    check("abort_left_burst", int'(burst_active), 0);
    cyc(10);

    // Debounce: 3-cycle glitch ignored, 4-cycle hold accepted.
    base_r = rises;
    press(3);
    cyc(15);
    check("glitch_no_burst", rises - base_r, 0);
    press(4);
    cyc(6);
    check("hold_burst", rises - base_r, 1);
    check("hold_burst_active", int'(burst_active), 1);
    press(8);
    cyc(15);

    // Randomized phase with one reset in mid-operation.
    hold = 0;
    rst_at = $urandom_range(500, 2500);
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin btn = ~btn; hold = $urandom_range(1, 12); end
      else hold--;
      r = $urandom_range(0, 31);
      if (r < 4) pos = (pos + 1) % 4;
      else if (r < 8) pos = (pos + 3) % 4;
      else if (r == 8) pos = (pos + 2) % 4;
      {enc_a, enc_b} = gray_code(pos);
      pulse_in = ($urandom_range(0, 2) == 0);
      if (i == rst_at) rst_n = 1'b0;
      if (i == rst_at + 3) rst_n = 1'b1;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_rate_controller.md
# pulse_rate_controller

Sequencing controller for the LFSR random pulse generator. Decodes a rotary encoder into the generator's 2-bit `frequency` select and debounces a start/stop button. Runs a burst FSM that passes a fixed number of generator pulses to the output, then enforces a cooldown. Sits between the board I/O (encoder, button) and the pulse generator instance.

## Interface
Parameters:
- `BURST_LEN`, 16: generator pulses forwarded per burst; legal range 1..255.
- `COOLDOWN`, 1024: idle cycles after a burst ends; legal range 1..65535.
- `DEBOUNCE`, 4: consecutive stable cycles required to accept a new button level; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all logic rises on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enc_a`, `enc_b`  in  1 each: asynchronous quadrature encoder inputs.
- `btn`  in  1: asynchronous start/stop button, active high.
- `pulse_in`  in  1: registered pulse output of the generator; synchronous to `clk`.
- `frequency`  out  2: rate select to the generator; `00` is slowest, `11` is fastest.
- `pulse_out`  out  1: one-cycle strobe per forwarded pulse.
- `burst_active`  out  1: high while in BURST.
- `pulse_count`  out  8: pulses forwarded in the current or most recent burst.

## Operation
- Synchronisers:
  - `enc_a`, `enc_b` and `btn` each pass through a 2-flop synchroniser.
  - A third register holds the previous synchronised encoder pair.
- Quadrature decode:
  - Gray sequence 00→01→11→10→00 is +1; the reverse is −1.
  - A change of both bits, or no change, gives no step.
  - Each step adjusts a 2-bit `pending` value, saturating at 0 and 3 with no wrap.
- Frequency apply:
  - `frequency` loads `pending` on every cycle the FSM is in IDLE, or is entering IDLE.
  - In BURST and COOLDOWN, `frequency` is frozen. Steps still accumulate in `pending`.
- Debounce:
  - The debounced level changes after the synchronised `btn` differs from it for `DEBOUNCE` consecutive cycles.
  - Any agreeing cycle clears the counter.
  - A rising edge of the debounced level produces a one-cycle `req`.
- Burst FSM (states IDLE, BURST, COOLDOWN):
  - IDLE, on `req`: go to BURST and clear `pulse_count` to 0.
  - BURST, on each rising edge of `pulse_in` (current 1, previous 0): assert `pulse_out` on the next cycle and increment `pulse_count`.
  - BURST, when `pulse_count` reaches `BURST_LEN`: go to COOLDOWN and load the timer with `COOLDOWN`.
  - BURST, on `req` (abort): go to COOLDOWN immediately; `pulse_count` holds its value.
  - BURST, when `req` and a pulse edge occur in the same cycle: the abort wins and no strobe is emitted.
  - COOLDOWN: the timer decrements each cycle; at 1 the FSM goes to IDLE. `req` is ignored.
- Counter widths: `pulse_count` is 8 bits and the cooldown timer is 16 bits; neither ever wraps.
- Reset mid-operation: all state returns to the reset values below on the next `rst_n` low, with no wait for the burst to finish.

## Timing
- Reset values:
  - `frequency`=00, `pending`=00.
  - `pulse_out`=0, `burst_active`=0, `pulse_count`=0.
  - FSM in IDLE; debounced level 0; all synchroniser flops 0.
- Encoder to `frequency` in IDLE: an input change before edge k appears on `frequency` after edge k+3.
- Button to FSM: `btn` rises before edge k; held stable, BURST is entered at edge k+2+`DEBOUNCE`+1.
- `pulse_in` rising edge sampled at edge n gives `pulse_out` high during n+1 to n+2, for exactly one cycle.
- Burst termination: the edge that increments `pulse_count` to `BURST_LEN` also moves the FSM to COOLDOWN. `burst_active` falls on that same edge.
- COOLDOWN lasts exactly `COOLDOWN` cycles, then IDLE.

## Configuration
- `PULSE_RATE_AUTO_REPEAT_EN`:
  - Defined: COOLDOWN expiry returns to BURST, clearing `pulse_count`, instead of IDLE. `req` in BURST or COOLDOWN goes to IDLE directly. `frequency` updates during COOLDOWN as well as IDLE.
  - Undefined: behaviour is exactly as described in Operation.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs are 0 and `frequency`=00. Release, with no input activity for 100 cycles → outputs stay at their reset values.
- Encoder saturation: 5 CW gray steps in IDLE → `frequency` goes 01, 10, 11, 11, 11. Then 5 CCW steps → down to 00. A 00→11 jump → no change.
- Burst: `BURST_LEN`=4, `COOLDOWN`=10, then press the button. Feed 6 `pulse_in` edges → exactly 4 `pulse_out` strobes, each 1 cycle after its edge, and `pulse_count`=4. COOLDOWN lasts 10 cycles, then IDLE.
- Abort: press again after 2 forwarded pulses → COOLDOWN and `pulse_count` holds 2. A simultaneous pulse edge gives no strobe.
- Frozen frequency: 2 CW steps during BURST → `frequency` unchanged until the IDLE entry edge, then `pending`=10 is applied.
- Debounce: `DEBOUNCE`=4 with a `btn` glitch of 3 cycles → no burst. A 4-cycle hold → burst starts; with `PULSE_RATE_AUTO_REPEAT_EN` defined → the burst repeats after cooldown until the next press.
